ls_issue_queue: RTL
===================

Name: ls_issue_queue

Overview:
- Parametrised in-order load/store queue between dispatcher and LSU.
- Holds up to DEPTH memory ops and snoops NUM_BCAST result-broadcast channels to wake up pending base/store-data operands.
- Computes the effective address internally and issues strictly in program order through a registered valid/ready stage.
- Retires entries only when the LSU signals completion.

Parameters:
DEPTH, 8, queue entries; power of two, >=2
DATA_W, 32, operand/immediate/address width
TAG_W, 4, rename tag width
NAME_W, 5, architectural destination register width
OP_W, 6, opcode width
NUM_BCAST, 2, number of result broadcast channels snooped
TAG_NONE, 0, tag value meaning "operand already valid"

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  synchronous queue clear (mispredict)
bc_valid  in  NUM_BCAST  per-channel broadcast valid
bc_tag  in  NUM_BCAST*TAG_W  packed broadcast tags, channel 0 in LSBs
bc_data  in  NUM_BCAST*DATA_W  packed broadcast data
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept this cycle
disp_op  in  OP_W  load/store opcode
disp_base, disp_base_tag  in  DATA_W, TAG_W  base operand value/tag
disp_src, disp_src_tag  in  DATA_W, TAG_W  store-data operand value/tag
disp_imm  in  DATA_W  offset
disp_tag_w  in  TAG_W  destination rename tag
disp_name_w  in  NAME_W  destination register
iss_valid  out  1  issue stage holds an op
iss_ready  in  1  LSU accepts op
iss_addr  out  DATA_W  base+imm, modulo 2^DATA_W
iss_data  out  DATA_W  store data
iss_op  out  OP_W
iss_tag_w  out  TAG_W
iss_name_w  out  NAME_W
lsu_done  in  1  LSU finished oldest in-flight op
count  out  $clog2(DEPTH+1)  occupied entries (waiting + in-flight)

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All entries empty; head, issue and tail pointers 0; count 0; iss_valid 0.
- Reset values of the issue outputs: iss_addr, iss_data, iss_tag_w, iss_name_w 0; iss_op 0 (NOP).
- Three pointers:
  - tail: next free entry.
  - issue: oldest not-yet-issued entry.
  - head: oldest in-flight entry.
  - All wrap DEPTH-1 -> 0.
- disp_ready = (count < DEPTH). Readiness is not relieved by a same-cycle lsu_done.
- Dispatch: disp_valid & disp_ready at an edge writes the entry at tail and advances tail.
- Wakeup: each operand tag is compared against every bc_valid channel every cycle. On a match, the operand captures the data and its tag becomes TAG_NONE.
  - Dispatch-cycle bypass: if a dispatched operand tag matches a broadcast in the same cycle, the entry is written with the broadcast data already valid.
  - If two channels carry the same tag, the lowest channel index wins.
- Entry ready = both operand tags == TAG_NONE. Loads always dispatch with disp_src_tag = TAG_NONE.
- Issue register loads when (!iss_valid | iss_ready) and the entry at the issue pointer is occupied and ready. Loading advances the issue pointer.
  - If the issue-pointer entry is not ready, nothing younger issues: strict order, no bypass of a stalled op.
  - iss_valid & !iss_ready holds all iss_* stable.
  - Back-to-back issue at one op/cycle while iss_ready=1.
- Latency: an op dispatched ready at edge T presents iss_valid after edge T+1. A broadcast at edge T waking the issue-pointer entry gives iss_valid after T+1.
- lsu_done: frees the head entry, advances head, decrements count.
  - Ignored when no op is in flight (head == issue and no held issue register).
  - Simultaneous dispatch and done leave count unchanged.
- Full/empty are distinguished by count, not by pointer equality.
- flush, synchronous: empties all entries, zeroes all pointers and count, clears iss_valid. It overrides same-cycle dispatch, issue and done. In-flight ops are abandoned; lsu_done in the cycle after flush is ignored.
- Reset mid-operation: rst asserted at any time returns all state to the reset values immediately, independent of clk.

Test Plan:
1. Reset, dispatch load base=0x100 tag NONE imm=0x8, iss_ready=1 -> iss_valid two edges later, iss_addr=0x108; lsu_done -> count 0.
2. Dispatch store base tag 3, src tag 5; bc ch0 tag3=0x2000 then ch1 tag5=0xAB -> issues only after second broadcast, iss_addr=0x2000+imm, iss_data=0xAB.
3. Oldest op waits on tag 7 while younger op is ready -> younger never issues first; broadcast tag 7 -> both issue in order on consecutive cycles.
4. Fill DEPTH=8 entries -> disp_ready=0 at count 8; disp_valid with lsu_done same cycle is not accepted; next cycle disp_ready=1; pointers wrap to 0 correctly.
5. Dispatch with base tag 2 while bc ch1 broadcasts tag 2=0x40 same cycle -> entry captured ready, iss_addr=0x40+imm.
6. Hold iss_ready=0 for 3 cycles with iss_valid=1 -> iss_* stable. flush mid-stream -> count 0, iss_valid 0 next cycle, lsu_done ignored.

Source files
------------

// File: rtl/ls_issue_queue.sv
// In-order load/store issue queue: snoops result broadcasts, computes base+imm,
// issues strictly in program order through a registered stage, retires on lsu_done.
module ls_issue_queue #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned NAME_W    = 5,
    parameter int unsigned OP_W      = 6,
    parameter int unsigned NUM_BCAST = 2,
    parameter int unsigned TAG_NONE  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_BCAST-1:0]          bc_valid,
    input  logic [NUM_BCAST*TAG_W-1:0]    bc_tag,
    input  logic [NUM_BCAST*DATA_W-1:0]   bc_data,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [OP_W-1:0]               disp_op,
    input  logic [DATA_W-1:0]             disp_base,
    input  logic [TAG_W-1:0]              disp_base_tag,
    input  logic [DATA_W-1:0]             disp_src,
    input  logic [TAG_W-1:0]              disp_src_tag,
    input  logic [DATA_W-1:0]             disp_imm,
    input  logic [TAG_W-1:0]              disp_tag_w,
    input  logic [NAME_W-1:0]             disp_name_w,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [DATA_W-1:0]             iss_addr,
    output logic [DATA_W-1:0]             iss_data,
    output logic [OP_W-1:0]               iss_op,
    output logic [TAG_W-1:0]              iss_tag_w,
    output logic [NAME_W-1:0]             iss_name_w,
    input  logic                          lsu_done,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [TAG_W-1:0] NONE = TAG_W'(TAG_NONE);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] base_q     [DEPTH];
    logic [DATA_W-1:0] base_d     [DEPTH];
    logic [TAG_W-1:0]  base_tag_q [DEPTH];
    logic [TAG_W-1:0]  base_tag_d [DEPTH];
    logic [DATA_W-1:0] src_q      [DEPTH];
    logic [DATA_W-1:0] src_d      [DEPTH];
    logic [TAG_W-1:0]  src_tag_q  [DEPTH];
    logic [TAG_W-1:0]  src_tag_d  [DEPTH];
    logic [DATA_W-1:0] imm_q      [DEPTH];
    logic [OP_W-1:0]   op_q       [DEPTH];
    logic [TAG_W-1:0]  tag_w_q    [DEPTH];
    logic [NAME_W-1:0] name_w_q   [DEPTH];

    logic [PTR_W-1:0] head_q, issue_q, tail_q;
    // count_q: all occupied entries; issued_q: the in-flight subset (head..issue)
    logic [CNT_W-1:0] count_q, issued_q, waiting;
    logic             disp_fire, done_fire, iss_load;

    assign disp_ready = (count_q < FULL);
    assign disp_fire  = disp_valid & disp_ready;
    assign done_fire  = lsu_done & (issued_q != '0);
    assign waiting    = count_q - issued_q;
    assign iss_load   = (!iss_valid || iss_ready) && (waiting != '0) &&
                        (base_tag_q[issue_q] == NONE) && (src_tag_q[issue_q] == NONE);
    assign count      = count_q;

    // Lowest channel wins: scan high to low so the last match is the lowest index.
    function automatic void snoop(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] val,
                                  output logic [TAG_W-1:0] tag_n,
                                  output logic [DATA_W-1:0] val_n);
        tag_n = tag;
        val_n = val;
        if (tag != NONE) begin
            for (int c = int'(NUM_BCAST) - 1; c >= 0; c--) begin
                if (bc_valid[c] && (bc_tag[c*TAG_W +: TAG_W] == tag)) begin
                    tag_n = NONE;
                    val_n = bc_data[c*DATA_W +: DATA_W];
                end
            end
        end
    endfunction

    always_comb begin
        for (int e = 0; e < int'(DEPTH); e++) begin
            if (disp_fire && (tail_q == PTR_W'(e))) begin
                snoop(disp_base_tag, disp_base, base_tag_d[e], base_d[e]);
                snoop(disp_src_tag, disp_src, src_tag_d[e], src_d[e]);
            end else begin
                snoop(base_tag_q[e], base_q[e], base_tag_d[e], base_d[e]);
                snoop(src_tag_q[e], src_q[e], src_tag_d[e], src_d[e]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                base_q[e]     <= '0;
                base_tag_q[e] <= NONE;
                src_q[e]      <= '0;
                src_tag_q[e]  <= NONE;
                imm_q[e]      <= '0;
                op_q[e]       <= '0;
                tag_w_q[e]    <= '0;
                name_w_q[e]   <= '0;
            end
            head_q     <= '0;
            issue_q    <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            iss_valid  <= 1'b0;
            iss_addr   <= '0;
            iss_data   <= '0;
            iss_op     <= '0;
            iss_tag_w  <= '0;
            iss_name_w <= '0;
        end else if (flush) begin
            head_q    <= '0;
            issue_q   <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            issued_q  <= '0;
            iss_valid <= 1'b0;
        end else begin
            base_q     <= base_d;
            base_tag_q <= base_tag_d;
            src_q      <= src_d;
            src_tag_q  <= src_tag_d;
            if (disp_fire) begin
                imm_q[tail_q]    <= disp_imm;
                op_q[tail_q]     <= disp_op;
                tag_w_q[tail_q]  <= disp_tag_w;
                name_w_q[tail_q] <= disp_name_w;
                tail_q           <= tail_q + PTR_W'(1);
            end
            if (iss_load) begin
                iss_valid  <= 1'b1;
                iss_addr   <= base_q[issue_q] + imm_q[issue_q];
                iss_data   <= src_q[issue_q];
                iss_op     <= op_q[issue_q];
                iss_tag_w  <= tag_w_q[issue_q];
                iss_name_w <= name_w_q[issue_q];
                issue_q    <= issue_q + PTR_W'(1);
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
            if (done_fire) begin
                head_q <= head_q + PTR_W'(1);
            end
            count_q  <= count_q + CNT_W'(disp_fire) - CNT_W'(done_fire);
            issued_q <= issued_q + CNT_W'(iss_load) - CNT_W'(done_fire);
        end
    end

endmodule
